// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack-ISA core with req/ack instruction and data buses.
// One instruction walks FETCH -> EXEC -> (READ) -> (WRITE) and commits
// A/D/pc/retired in a single cycle. Wait states on either bus stretch the
// state that owns the request. A jump onto itself, or back onto the
// @target that loaded A, parks the core in HALT until reset.
module hack_cpu_mc #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 15,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              instr_valid,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halt,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] res_reg;
  logic              prev_a;

  logic              commit;
  logic              load_ir;
  logic              load_res;

  logic              is_c;
  logic              use_m;
  logic              dest_a;
  logic              dest_d;
  logic              dest_m;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] commit_res;
  logic              zr;
  logic              ng;
  logic              do_jump;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_dec;
  logic              halt_hit;

  // Standard Hack ALU: optional zero/invert on each operand, add or and,
  // optional invert of the result. Addition wraps at DATA_W bits.
  function automatic logic [DATA_W-1:0] hack_alu(
    input logic [DATA_W-1:0] x_in,
    input logic [DATA_W-1:0] y_in,
    input logic [5:0]        ctl
  );
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] o;
    x = ctl[5] ? '0 : x_in;
    x = ctl[4] ? ~x : x;
    y = ctl[3] ? '0 : y_in;
    y = ctl[2] ? ~y : y;
    o = ctl[1] ? (x + y) : (x & y);
    o = ctl[0] ? ~o : o;
    return o;
  endfunction

  // Instruction field decode; only ir[12:0] carries C-instruction fields.
  assign is_c   = ir[DATA_W-1];
  assign use_m  = ir[12];
  assign dest_a = ir[5];
  assign dest_d = ir[4];
  assign dest_m = ir[3];
  assign imm    = {1'b0, ir[DATA_W-2:0]};

  // The M operand is only live during READ; otherwise the ALU sees A.
  // A result parked for WRITE is committed from res_reg.
  assign alu_y      = (state == S_READ) ? mem_rdata : a_reg;
  assign alu_out    = hack_alu(d_reg, alu_y, ir[11:6]);
  assign commit_res = (state == S_WRITE) ? res_reg : alu_out;

  assign zr       = (commit_res == '0);
  assign ng       = commit_res[DATA_W-1];
  assign do_jump  = is_c & ((ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~zr & ~ng));
  assign target   = a_reg[ADDR_W-1:0];
  assign pc_inc   = pc + ADDR_W'(1);
  assign pc_dec   = pc - ADDR_W'(1);
  assign halt_hit = do_jump & ((target == pc) | ((target == pc_dec) & prev_a));

  // Bus requests are gated by reset so they drop the instant reset asserts.
  assign instr_req  = reset & (state == S_FETCH);
  assign mem_rd     = reset & (state == S_READ);
  assign mem_we     = reset & (state == S_WRITE);
  assign instr_addr = pc;
  assign mem_addr   = a_reg[ADDR_W-1:0];
  assign mem_wdata  = res_reg;
  assign halt       = (state == S_HALT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    load_ir    = 1'b0;
    load_res   = 1'b0;
    case (state)
      S_FETCH: begin
        if (instr_valid) begin
          load_ir    = 1'b1;
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!is_c) begin
          commit     = 1'b1;
          next_state = S_FETCH;
        end else if (use_m) begin
          next_state = S_READ;
        end else if (dest_m) begin
          load_res   = 1'b1;
          next_state = S_WRITE;
        end else begin
          commit     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          if (dest_m) begin
            load_res   = 1'b1;
            next_state = S_WRITE;
          end else begin
            commit     = 1'b1;
            next_state = S_FETCH;
          end
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          commit     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
    if (commit && halt_hit) begin
      next_state = S_HALT;
    end
  end

  // Architectural state: instruction latch and the single-cycle commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VECTOR;
      a_reg   <= '0;
      d_reg   <= '0;
      ir      <= '0;
      retired <= '0;
      prev_a  <= 1'b0;
    end else begin
      if (load_ir) begin
        ir <= instr_data;
      end
      if (commit) begin
        retired <= retired + 32'd1;
        prev_a  <= ~is_c;
        pc      <= do_jump ? target : pc_inc;
        if (!is_c) begin
          a_reg <= imm;
        end else begin
          if (dest_a) begin
            a_reg <= commit_res;
          end
          if (dest_d) begin
            d_reg <= commit_res;
          end
        end
      end
    end
  end

  // Result held for the WRITE state; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (load_res) begin
      res_reg <= alu_out;
    end
  end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: the bench plays ROM and RAM with random wait states
// and spurious strobes, and follows an instruction-level Hack interpreter.
module tb_hack_cpu_mc;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] instr_data = '0;
  logic              instr_valid = 1'b0;
  logic              mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              halt;
  logic [31:0]       retired;

  hack_cpu_mc #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RESET_VECTOR(15'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr_req(instr_req),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .instr_valid(instr_valid),
    .mem_rd(mem_rd),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .pc(pc),
    .halt(halt),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] rom     [MEM_N];
  logic [15:0] dut_ram [MEM_N];
  logic [15:0] ref_ram [MEM_N];
  logic [5:0]  comps   [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
                                6'b110000, 6'b001101, 6'b110001, 6'b001111,
                                6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                6'b110010, 6'b000010, 6'b010011, 6'b000111,
                                6'b000000, 6'b010101};

  int total = 0;
  int bad   = 0;

  // Reference machine state and the instruction currently in flight.
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [31:0] m_ret;
  bit          m_prev_a, m_halt;
  bit          pend, exec_seen, rd_left, wr_left, post_chk;
  logic [14:0] x_addr;
  logic [15:0] x_wdata;
  int          halt_cyc;

  int          last_kind;
  bit          last_ack;
  logic [14:0] last_addr, last_pc;
  logic [15:0] last_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hack computations by their arithmetic meaning.
  function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] d, input logic [15:0] a);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return a;
      6'b001101: return ~d;
      6'b110001: return ~a;
      6'b001111: return 16'd0 - d;
      6'b110011: return 16'd0 - a;
      6'b011111: return d + 16'd1;
      6'b110111: return a + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return a - 16'd1;
      6'b000010: return d + a;
      6'b010011: return d - a;
      6'b000111: return a - d;
      6'b000000: return d & a;
      6'b010101: return d | a;
      default:   return 16'hDEAD;
    endcase
  endfunction

  // Execute one whole instruction on the reference machine; memory writes
  // are deferred until the DUT's write is acknowledged.
  task automatic model_exec(input logic [15:0] inst);
    logic [15:0] y, r;
    logic [14:0] tgt;
    bit          jmp;
    rd_left = 1'b0;
    wr_left = 1'b0;
    if (!inst[15]) begin
      m_a      = {1'b0, inst[14:0]};
      m_pc     = m_pc + 15'd1;
      m_prev_a = 1'b1;
    end else begin
      tgt     = m_a[14:0];
      x_addr  = tgt;
      y       = inst[12] ? ref_ram[tgt] : m_a;
      r       = ref_comp(inst[11:6], m_d, y);
      rd_left = inst[12];
      if (inst[3]) begin
        wr_left = 1'b1;
        x_wdata = r;
      end
      jmp = (inst[2] && $signed(r) < 0) || (inst[1] && r == 16'd0) || (inst[0] && $signed(r) > 0);
      if (jmp && (tgt == m_pc || (tgt == m_pc - 15'd1 && m_prev_a))) m_halt = 1'b1;
      if (inst[5]) m_a = r;
      if (inst[4]) m_d = r;
      m_pc     = jmp ? tgt : m_pc + 15'd1;
      m_prev_a = 1'b0;
    end
    m_ret = m_ret + 32'd1;
  endtask

  // One clock of bus service and checking, at the falling edge.
  task automatic step(input bit zw);
    bit ack;
    int kind;
    @(negedge clk);
    ack = zw || ($urandom_range(0, 2) != 0);
    if (post_chk) begin
      check_val("commit_pc", 32'(pc), 32'(m_pc));
      check_val("commit_retired", retired, m_ret);
      check_val("commit_halt", 32'(halt), 32'(m_halt));
      post_chk = 1'b0;
      pend     = 1'b0;
    end
    check_val("one_req", 32'($countones({instr_req, mem_rd, mem_we}) <= 1), 32'd1);
    kind = instr_req ? 1 : mem_rd ? 2 : mem_we ? 3 : 0;
    if (kind != 0 && kind == last_kind && !last_ack) begin
      check_val("hold_addr", 32'(kind == 1 ? instr_addr : mem_addr), 32'(last_addr));
      check_val("hold_pc", 32'(pc), 32'(last_pc));
      if (kind == 3) check_val("hold_wdata", 32'(mem_wdata), 32'(last_wdata));
    end
    instr_valid = 1'($urandom_range(0, 1));
    mem_ack     = 1'($urandom_range(0, 1));
    instr_data  = 16'($urandom);
    mem_rdata   = 16'($urandom);
    if (pend && !exec_seen) begin
      exec_seen = 1'b1;
      ack       = 1'b0;
      check_val("exec_idle", 32'(kind), 32'd0);
      if (!rd_left && !wr_left) post_chk = 1'b1;
    end else if (m_halt && !pend) begin
      ack = 1'b0;
      check_val("halt_quiet", 32'(kind), 32'd0);
      check_val("halt_flag", 32'(halt), 32'd1);
      halt_cyc++;
    end else begin
      case (kind)
        1: begin
          check_val("fetch_idle_core", 32'(pend), 32'd0);
          check_val("fetch_addr", 32'(instr_addr), 32'(m_pc));
          instr_valid = ack;
          if (ack) begin
            instr_data = rom[instr_addr];
            model_exec(rom[m_pc]);
            pend      = 1'b1;
            exec_seen = 1'b0;
          end
        end
        2: begin
          check_val("rd_expected", 32'(rd_left & pend & exec_seen), 32'd1);
          check_val("rd_addr", 32'(mem_addr), 32'(x_addr));
          mem_ack = ack;
          if (ack) begin
            mem_rdata = dut_ram[mem_addr];
            rd_left   = 1'b0;
            if (!wr_left) post_chk = 1'b1;
          end
        end
        3: begin
          check_val("wr_expected", 32'(wr_left & ~rd_left & pend & exec_seen), 32'd1);
          check_val("wr_addr", 32'(mem_addr), 32'(x_addr));
          check_val("wr_data", 32'(mem_wdata), 32'(x_wdata));
          mem_ack = ack;
          if (ack) begin
            dut_ram[mem_addr] = mem_wdata;
            ref_ram[x_addr]   = x_wdata;
            wr_left  = 1'b0;
            post_chk = 1'b1;
          end
        end
        default: begin
          check_val("req_present", 32'(kind != 0), 32'd1);
        end
      endcase
    end
    last_kind  = kind;
    last_ack   = ack;
    last_addr  = (kind == 1) ? instr_addr : mem_addr;
    last_wdata = mem_wdata;
    last_pc    = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    instr_valid = 1'b1;
    mem_ack     = 1'b1;
    #1;
    check_val("rst_instr_req", 32'(instr_req), 32'd0);
    check_val("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_retired", retired, 32'd0);
    check_val("rst_halt", 32'(halt), 32'd0);
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    instr_valid = 1'b0;
    mem_ack   = 1'b1;
    m_a = '0; m_d = '0; m_pc = '0; m_ret = '0;
    m_prev_a = 1'b0; m_halt = 1'b0;
    pend = 1'b0; exec_seen = 1'b0; rd_left = 1'b0; wr_left = 1'b0; post_chk = 1'b0;
    last_kind = 0; last_ack = 1'b1;
  endtask

  task automatic run_prog(input int limit, input bit zw);
    int  cyc, over;
    bit  done;
    cyc = 0; over = 0; halt_cyc = 0; done = 1'b0;
    while (!done) begin
      step(zw);
      cyc++;
      if (m_ret >= 32'(limit)) over++;
      if (m_halt && !pend && halt_cyc >= 6) done = 1'b1;
      else if (over > 0 && ((last_kind == 3 && !last_ack) || over > 30)) done = 1'b1;
      if (cyc > 6000) begin
        check_val("prog_cycle_budget", 32'(cyc), 32'd6000);
        done = 1'b1;
      end
      if (bad > 40) done = 1'b1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MEM_N; i++) begin
      rom[i] = 16'h0000;
      dut_ram[i] = 16'h0000;
      ref_ram[i] = 16'h0000;
    end
  endtask

  task automatic gen_random();
    int r, h;
    for (int i = 0; i < MEM_N; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      rom[i] = {1'b0, 15'($urandom_range(0, 63))};
      else if (r < 40) rom[i] = {1'b0, 15'($urandom)};
      else rom[i] = {3'b111, 1'($urandom), comps[$urandom_range(0, 17)], 3'($urandom),
                     ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000};
      dut_ram[i] = 16'($urandom);
      ref_ram[i] = dut_ram[i];
    end
    for (int k = 0; k < 4; k++) begin
      h = $urandom_range(0, 62);
      rom[h]     = {1'b0, 15'(h)};
      rom[h + 1] = 16'hEA87;
    end
  endtask

  initial begin
    // Program 0: D=2+3, M[0]=D, then halt loop at 6/7, zero-wait memory.
    clear_mem();
    rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE090;
    rom[4] = 16'h0000; rom[5] = 16'hE308; rom[6] = 16'h0006; rom[7] = 16'hEA87;
    do_reset();
    run_prog(1000, 1'b1);
    check_val("p0_ram0", 32'(dut_ram[0]), 32'h0005);
    check_val("p0_halt_pc", 32'(pc), 32'd6);
    check_val("p0_retired", retired, 32'd8);

    // Program 1: D=M[0x10], M[0x11]=D, halt; random waits.
    clear_mem();
    dut_ram[16'h10] = 16'h1234; ref_ram[16'h10] = 16'h1234;
    rom[0] = 16'h0010; rom[1] = 16'hFC10; rom[2] = 16'h0011; rom[3] = 16'hE308;
    rom[4] = 16'h0004; rom[5] = 16'hEA87;
    do_reset();
    run_prog(1000, 1'b0);
    check_val("p1_ram11", 32'(dut_ram[16'h11]), 32'h1234);

    // Program 2: D=0; @9; D;JEQ taken; at 9/10 a jump onto itself halts.
    clear_mem();
    rom[0] = 16'hEA90; rom[1] = 16'h0009; rom[2] = 16'hE302;
    rom[9] = 16'h000A; rom[10] = 16'hEA87;
    do_reset();
    run_prog(1000, 1'b0);
    check_val("p2_halt_pc", 32'(pc), 32'd10);

    // Program 3: D=-1; @9; D;JGT not taken; halt at 3/4.
    clear_mem();
    rom[0] = 16'hEE90; rom[1] = 16'h0009; rom[2] = 16'hE301;
    rom[3] = 16'h0003; rom[4] = 16'hEA87;
    do_reset();
    run_prog(1000, 1'b0);
    check_val("p3_halt_pc", 32'(pc), 32'd3);

    // Program 4: jump back by one after a C-instruction is a loop, not a halt.
    clear_mem();
    rom[0] = 16'h0001; rom[1] = 16'hEC10; rom[2] = 16'hEA87;
    do_reset();
    run_prog(40, 1'b0);
    check_val("p4_running", 32'(halt), 32'd0);

    // Random programs, mixed wait states, reset wherever the run ends.
    for (int p = 0; p < 8 && bad <= 40; p++) begin
      gen_random();
      do_reset();
      run_prog(150, p == 0);
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
